instr_decode_stage: RTL and testbench

- Registered RV32/RV64 instruction decode stage: splits a 32-bit instruction into its fields and builds the format-correct, sign-extended immediate.
- Flags illegal encodings and counts them.
- Sits between fetch and register-read. valid/ready handshake on both sides; 2-entry skid buffer so in_ready is registered.

---
 rtl/instr_decode_stage.sv | 193 +++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Registered RV32/RV64 instruction decode stage with a 2-entry skid buffer.
// Splits the instruction into fields, builds the sign-extended immediate and flags/counts illegal encodings.
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [31:0]      skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic             out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept, xfer, out_free, load_out;
    logic [31:0]      src_instr;
    logic [PC_W-1:0]  src_pc;
    logic [2:0]       dec_fmt;
    logic [31:0]      dec_imm32;
    logic [XLEN-1:0]  dec_imm;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;

    // The skid entry is always older than anything on the input, so it wins the output register.
    assign src_instr = skid_valid_q ? skid_instr_q : in_instr;
    assign src_pc    = skid_valid_q ? skid_pc_q    : in_pc;

    // Every listed opcode ends in 2'b11, so the low-bit check falls out of the opcode match.
    always_comb begin
        dec_fmt = FMT_ILL;
        case (src_instr[6:0])
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: dec_fmt = FMT_I;
            7'b0011011:             if (XLEN == 64) dec_fmt = FMT_I;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0100011:             dec_fmt = FMT_S;
            7'b0110011:             dec_fmt = FMT_R;
            7'b0111011:             if (XLEN == 64) dec_fmt = FMT_R;
            default:                dec_fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_fmt)
            FMT_I:   dec_imm32 = {{20{src_instr[31]}}, src_instr[31:20]};
            FMT_S:   dec_imm32 = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
            FMT_B:   dec_imm32 = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                                  src_instr[30:25], src_instr[11:8], 1'b0};
            FMT_U:   dec_imm32 = {src_instr[31:12], 12'd0};
            FMT_J:   dec_imm32 = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                                  src_instr[20], src_instr[30:21], 1'b0};
            default: dec_imm32 = 32'd0;
        endcase
    end

    // All immediates fit in 32 bits; widening a signed value carries bit 31 up to XLEN.
    assign dec_imm = XLEN'($signed(dec_imm32));

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        out_imm_d     = out_imm_q;
        out_fmt_d     = out_fmt_q;
        out_illegal_d = out_illegal_q;
        load_out      = 1'b0;

        if (out_free) begin
            if (skid_valid_q) begin
                load_out     = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                end
            end else if (accept) begin
                load_out = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
        end

        if (load_out) begin
            out_valid_d   = 1'b1;
            out_instr_d   = src_instr;
            out_pc_d      = src_pc;
            out_imm_d     = dec_imm;
            out_fmt_d     = dec_fmt;
            out_illegal_d = (dec_fmt == FMT_ILL);
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // Counts delivered illegal entries; a transfer in a flush cycle still completes.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer && out_illegal_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            out_imm_q     <= '0;
            out_fmt_q     <= '0;
            out_illegal_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            out_imm_q     <= out_imm_d;
            out_fmt_q     <= out_fmt_d;
            out_illegal_q <= out_illegal_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_opcode  = out_instr_q[6:0];
    assign out_funct3  = out_instr_q[14:12];
    assign out_funct7  = out_instr_q[31:25];
    assign out_rs1     = out_instr_q[19:15];
    assign out_rs2     = out_instr_q[24:20];
    assign out_rd      = out_instr_q[11:7];
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: RV32 (a), RV64 (b) and 2-bit-counter (c) instances driven in lockstep,
// checked against a constant vector table and a queue-based flow/decode model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        a_in_ready, a_out_valid, a_illegal, b_in_ready, b_out_valid, b_illegal;
    logic        c_in_ready, c_out_valid, c_illegal;
    logic [31:0] a_instr, a_pc, b_instr, b_pc, c_instr, c_pc;
    logic [6:0]  a_opcode, a_funct7, b_opcode, b_funct7, c_opcode, c_funct7;
    logic [2:0]  a_funct3, a_fmt, b_funct3, b_fmt, c_funct3, c_fmt;
    logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd, c_rs1, c_rs2, c_rd;
    logic [31:0] a_imm, c_imm;
    logic [63:0] b_imm;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_instr), .out_pc(a_pc), .out_opcode(a_opcode), .out_funct3(a_funct3),
        .out_funct7(a_funct7), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_fmt(a_fmt), .out_illegal(a_illegal), .illegal_cnt(a_cnt));

    instr_decode_stage #(.XLEN(64), .PC_W(32), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_instr), .out_pc(b_pc), .out_opcode(b_opcode), .out_funct3(b_funct3),
        .out_funct7(b_funct7), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
        .out_fmt(b_fmt), .out_illegal(b_illegal), .illegal_cnt(b_cnt));

    instr_decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_instr(c_instr), .out_pc(c_pc), .out_opcode(c_opcode), .out_funct3(c_funct3),
        .out_funct7(c_funct7), .out_rs1(c_rs1), .out_rs2(c_rs2), .out_rd(c_rd), .out_imm(c_imm),
        .out_fmt(c_fmt), .out_illegal(c_illegal), .illegal_cnt(c_cnt));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode from the ISA rules: format from the major opcode, immediate as signed arithmetic.
    function automatic void ref_dec(input logic [31:0] i, input bit rv64,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        int f;
        longint v;
        f = 7;
        if (i[1:0] == 2'b11) begin
            case (i[6:2])
                5'b01101, 5'b00101:                               f = 4;
                5'b11011:                                         f = 5;
                5'b11001, 5'b00000, 5'b00100, 5'b00011, 5'b11100: f = 1;
                5'b00110:                                         f = rv64 ? 1 : 7;
                5'b11000:                                         f = 3;
                5'b01000:                                         f = 2;
                5'b01100:                                         f = 0;
                5'b01110:                                         f = rv64 ? 0 : 7;
                default:                                          f = 7;
            endcase
        end
        case (f)
            1: v = (i[31] ? -64'sd2048 : 64'sd0) + longint'(i[30:20]);
            2: v = (i[31] ? -64'sd2048 : 64'sd0) + longint'(i[30:25]) * 32 + longint'(i[11:7]);
            3: v = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 2048
                   + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            4: v = (i[31] ? -64'sd2147483648 : 64'sd0) + longint'(i[30:12]) * 4096;
            5: v = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 4096
                   + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default: v = 0;
        endcase
        imm = rv64 ? 64'(v) : {32'd0, v[31:0]};
        fmt = 3'(f);
    endfunction

    function automatic logic [31:0] fields_of(input logic [31:0] i);
        return {i[6:0], i[14:12], i[31:25], i[19:15], i[24:20], i[11:7]};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   cnt16 = 0, cnt64 = 0, cnt2 = 0;

    // One clock: settle the transfer/accept against the model, advance, then check occupancy and counters.
    task automatic step();
        bit          acc, xf;
        ent_t        e;
        logic [63:0] imm;
        logic [2:0]  fmt;
        acc = in_valid && a_in_ready;
        xf  = a_out_valid && out_ready;
        if (xf) begin
            if (q.size() == 0) begin
                chk("xfer_from_empty", a_out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("xfer_instr", a_instr, e.instr);
                chk("xfer_pc", a_pc, e.pc);
                chk("xfer_fields", {a_opcode, a_funct3, a_funct7, a_rs1, a_rs2, a_rd}, fields_of(e.instr));
                chk("b_fields", {b_opcode, b_funct3, b_funct7, b_rs1, b_rs2, b_rd, b_instr, b_pc},
                    {fields_of(e.instr), e.instr, e.pc});
                chk("c_fields", {c_opcode, c_funct3, c_funct7, c_rs1, c_rs2, c_rd, c_instr, c_pc},
                    {fields_of(e.instr), e.instr, e.pc});
                ref_dec(e.instr, 1'b0, imm, fmt);
                chk("xfer_imm32", a_imm, imm);
                chk("xfer_fmt32", a_fmt, fmt);
                chk("xfer_ill32", a_illegal, fmt == 3'd7);
                chk("c_dec", {c_imm, c_fmt, c_illegal}, {imm[31:0], fmt, fmt == 3'd7});
                if (fmt == 3'd7) begin
                    if (cnt16 < 65535) cnt16++;
                    if (cnt2 < 3) cnt2++;
                end
                ref_dec(e.instr, 1'b1, imm, fmt);
                chk("xfer_imm64", b_imm, imm);
                chk("xfer_fmt64", b_fmt, fmt);
                chk("xfer_ill64", b_illegal, fmt == 3'd7);
                if (fmt == 3'd7 && cnt64 < 65535) cnt64++;
            end
        end
        if (flush) q.delete();
        else if (acc) q.push_back('{in_instr, in_pc});
        @(posedge clk);
        #1;
        chk("out_valid", a_out_valid, q.size() > 0);
        chk("in_ready", a_in_ready, q.size() < 2);
        chk("bc_flow", {b_out_valid, b_in_ready, c_out_valid, c_in_ready},
            {q.size() > 0, q.size() < 2, q.size() > 0, q.size() < 2});
        chk("cnt16", a_cnt, cnt16);
        chk("cnt64", b_cnt, cnt64);
        chk("cnt2", c_cnt, cnt2);
    endtask

    // Asynchronous reset mid-cycle, with in_valid high to show it is ignored.
    task automatic do_reset();
        in_valid = 1'b1;
        in_instr = 32'h0000_0013;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_outs", {a_instr, a_pc, a_imm, a_fmt, a_illegal}, 0);
        chk("rst_cnt", {a_cnt, b_cnt, c_cnt}, 0);
        q.delete();
        cnt16 = 0; cnt64 = 0; cnt2 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
    } vec_t;

    vec_t vt[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got[$];
        logic [31:0] lui_exp[3];
        logic [1:0]  c_exp[5];
        logic [6:0]  ops[14];
        logic [31:0] r;

        vt[0]  = '{32'hFFF10093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
        vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
        vt[2]  = '{32'h00112623, 32'h0000000C, 3'd2, 64'h000000000000000C, 3'd2};
        vt[3]  = '{32'h12345037, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4};
        vt[4]  = '{32'h00000000, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};
        vt[5]  = '{32'h0000001B, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd1};
        vt[6]  = '{32'h80000037, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
        vt[7]  = '{32'h800000EF, 32'hFFF00000, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5};
        vt[8]  = '{32'h002081B3, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
        vt[9]  = '{32'h002081BB, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd0};
        vt[10] = '{32'h00000012, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};
        vt[11] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000, 3'd4};
        vt[12] = '{32'h80002083, 32'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1};
        vt[13] = '{32'h00008067, 32'h00000000, 3'd1, 64'h0000000000000000, 3'd1};
        vt[14] = '{32'h0040006F, 32'h00000004, 3'd5, 64'h0000000000000004, 3'd5};
        vt[15] = '{32'h00000057, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};
        vt[16] = '{32'h80000063, 32'hFFFFF000, 3'd3, 64'hFFFFFFFFFFFFF000, 3'd3};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", a_out_valid, 0);
        chk("reset_in_ready", a_in_ready, 1);
        chk("reset_outs", {a_instr, a_pc, a_imm, a_fmt, a_illegal}, 0);
        chk("reset_cnt", {a_cnt, b_cnt, c_cnt}, 0);
        rst = 1'b0;

        // Vector table: one entry at a time, compared against hand-derived constants.
        foreach (vt[k]) begin
            in_valid = 1'b1; in_instr = vt[k].instr; in_pc = 32'h1000 + 32'(k) * 4;
            step();
            in_valid = 1'b0;
            chk("tbl_latency", a_out_valid, 1);
            chk("tbl_imm32", a_imm, vt[k].imm32);
            chk("tbl_fmt32", a_fmt, vt[k].fmt32);
            chk("tbl_ill32", a_illegal, vt[k].fmt32 == 3'd7);
            chk("tbl_imm64", b_imm, vt[k].imm64);
            chk("tbl_fmt64", b_fmt, vt[k].fmt64);
            chk("tbl_ill64", b_illegal, vt[k].fmt64 == 3'd7);
            step();
        end

        // ADDI field split.
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h2000;
        step();
        in_valid = 1'b0;
        chk("addi_fields", {a_opcode, a_rd, a_rs1, a_funct3}, {7'h13, 5'd1, 5'd2, 3'd0});
        step();

        // BEQ then SW back to back at full rate.
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h3000;
        step();
        chk("beq_imm_fmt", {a_imm, a_fmt}, {32'hFFFFFFFC, 3'd3});
        in_instr = 32'h00112623; in_pc = 32'h3004;
        step();
        in_valid = 1'b0;
        chk("sw_imm_fmt", {a_imm, a_fmt}, {32'h0000000C, 3'd2});
        chk("sw_regs", {a_rs2, a_rs1}, {5'd1, 5'd2});
        step();

        // Backpressure: three LUIs into a stalled stage, then release.
        lui_exp = '{32'h12345000, 32'h00001000, 32'h00002000};
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h12345037; in_pc = 32'h4000;
        step();
        in_instr = 32'h00001037; in_pc = 32'h4004;
        step();
        chk("bp_in_ready_low", a_in_ready, 0);
        in_instr = 32'h00002037; in_pc = 32'h4008;
        step();
        step();
        out_ready = 1'b1;
        got.delete();
        for (int n = 0; n < 8; n++) begin
            if (a_out_valid && out_ready) got.push_back(a_imm);
            if (in_valid && a_in_ready) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        chk("bp_count", got.size(), 3);
        for (int n = 0; n < 3 && n < got.size(); n++) chk("bp_order", got[n], lui_exp[n]);

        // Two-bit counter saturation on five illegal transfers.
        do_reset();
        c_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        in_instr = 32'h0; in_pc = 32'h5000;
        for (int n = 0; n < 6; n++) begin
            in_valid = (n < 5);
            step();
            if (n >= 1) chk("cnt2_seq", c_cnt, c_exp[n-1]);
        end
        in_valid = 1'b0;
        step();

        // Flush with both registers full and an input presented.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00001037; in_pc = 32'h6000;
        step();
        in_instr = 32'h00000000; in_pc = 32'h6004;
        step();
        in_instr = 32'h00003037; in_pc = 32'h6008; flush = 1'b1;
        step();
        chk("flush_out_valid", a_out_valid, 0);
        chk("flush_in_ready", a_in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // Flush coinciding with an illegal transfer: the transfer still counts.
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h7000;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        step();

        // Reset while entries are buffered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h8000;
        step();
        step();
        do_reset();
        out_ready = 1'b1;
        step();

        // Randomized traffic against the model.
        ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h03, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h2B};
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 30) == 0);
            in_instr  = ($urandom_range(0, 9) == 0) ? r : {r[31:7], ops[$urandom_range(0, 13)]};
            in_pc     = $urandom();
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
